// File: rtl/avl_wb_bridge_if.sv
// ============================================================================
// avl_wb_bridge_if : Avalon-MM slave and Wishbone master signal bundle
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface avl_wb_bridge_if;
  logic [4:0]  avl_address;
  logic        avl_read;
  logic        avl_write;
  logic [31:0] avl_writedata;
  logic [3:0]  avl_byteenable;
  logic        avl_waitrequest;
  logic [31:0] avl_readdata;
  logic        avl_readdatavalid;
  logic [1:0]  avl_response;
  logic [2:0]  wb_adr_o;
  logic [7:0]  wb_dat_o;
  logic [7:0]  wb_dat_i;
  logic        wb_we_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i;
  logic        timeout_o;

  // Bridge side
  modport slave (
    input  avl_address, avl_read, avl_write, avl_writedata, avl_byteenable,
    input  wb_dat_i, wb_ack_i,
    output avl_waitrequest, avl_readdata, avl_readdatavalid, avl_response,
    output wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o, wb_sel_o, timeout_o
  );

  // System side: Avalon master plus Wishbone slave
  modport master (
    output avl_address, avl_read, avl_write, avl_writedata, avl_byteenable,
    output wb_dat_i, wb_ack_i,
    input  avl_waitrequest, avl_readdata, avl_readdatavalid, avl_response,
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o, wb_sel_o, timeout_o
  );
endinterface

`default_nettype wire

// File: rtl/avl_wb_bridge.sv
// ============================================================================
// avl_wb_bridge : Avalon-MM slave to 8-bit Wishbone master for a UART block.
// Optional Wishbone abort timer enabled by `define AVL_WB_BRIDGE_TIMEOUT_EN.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module avl_wb_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  avl_wb_bridge_if.slave   bus
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] WB_REQ = 1'b1;

  logic [0:0]  r_state;
  logic [0:0]  w_state_nxt;
  logic        r_init_done;
  logic        w_accept;
  logic        w_ack;
  logic        w_expire;
  logic [2:0]  r_adr;
  logic [7:0]  r_dat;
  logic        r_we;
  logic        r_rdv;
  logic [31:0] r_rdata;

  logic        w_waitrequest;
  logic        w_cyc;
  logic [2:0]  w_adr;
  logic [7:0]  w_dat;
  logic        w_we;

  assign w_accept = (r_state == IDLE) && r_init_done && (bus.avl_read || bus.avl_write);
  assign w_ack    = (r_state == WB_REQ) && bus.wb_ack_i;

`ifdef AVL_WB_BRIDGE_TIMEOUT_EN
  logic [15:0] r_to_cnt;
  logic [15:0] w_to_cnt_inc;
  logic        r_timeout;
  logic [1:0]  r_resp;

  assign w_to_cnt_inc = r_to_cnt + 16'd1;
  // Abort in the cycle that would bring the count to the limit; an ack wins.
  assign w_expire = (r_state == WB_REQ) && !bus.wb_ack_i
                    && (w_to_cnt_inc == 16'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt  <= 16'd0;
      r_timeout <= 1'b0;
      r_resp    <= 2'b00;
    end else begin
      if (w_accept)
        r_to_cnt <= 16'd0;
      else if ((r_state == WB_REQ) && !bus.wb_ack_i)
        r_to_cnt <= w_to_cnt_inc;
      r_timeout <= w_expire;
      r_resp    <= (w_expire && !r_we) ? 2'b10 : 2'b00;
    end
  end

  assign bus.timeout_o    = r_timeout;
  assign bus.avl_response = r_resp;
`else
  assign w_expire         = 1'b0;
  assign bus.timeout_o    = 1'b0;
  assign bus.avl_response = 2'b00;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = WB_REQ;
      WB_REQ:  if (w_ack || w_expire) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_waitrequest = 1'b1;
    w_cyc         = 1'b0;
    w_adr         = 3'd0;
    w_dat         = 8'd0;
    w_we          = 1'b0;
    case (r_state)
      IDLE: w_waitrequest = !w_accept;
      WB_REQ: begin
        w_cyc = 1'b1;
        w_adr = r_adr;
        w_dat = r_dat;
        w_we  = r_we;
      end
      default: w_waitrequest = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init_done <= 1'b0;
      r_adr       <= 3'd0;
      r_dat       <= 8'd0;
      r_we        <= 1'b0;
      r_rdv       <= 1'b0;
      r_rdata     <= 32'd0;
    end else begin
      r_init_done <= 1'b1;
      if (w_accept) begin
        r_adr <= bus.avl_address[4:2];
        r_dat <= bus.avl_writedata[7:0];
        r_we  <= bus.avl_write;
      end
      r_rdv <= (w_ack || w_expire) && !r_we;
      if (w_ack && !r_we)
        r_rdata <= {24'd0, bus.wb_dat_i};
      else if (w_expire && !r_we)
        r_rdata <= 32'd0;
    end
  end

  assign bus.avl_waitrequest   = w_waitrequest;
  assign bus.avl_readdata      = r_rdata;
  assign bus.avl_readdatavalid = r_rdv;
  assign bus.wb_cyc_o          = w_cyc;
  assign bus.wb_stb_o          = w_cyc;
  assign bus.wb_adr_o          = w_adr;
  assign bus.wb_dat_o          = w_dat;
  assign bus.wb_we_o           = w_we;
  assign bus.wb_sel_o          = 4'b0001;

  logic w_unused;
  assign w_unused = ^{bus.avl_address[1:0], bus.avl_writedata[31:8], bus.avl_byteenable};

endmodule

`default_nettype wire

// File: doc/avl_wb_bridge.md
AVL_WB_BRIDGE -- requirements
Module: avl_wb_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the Wishbone cycles allowed before abort; legal range 1..65535.
REQ-002 clk  in  1  single clock for all logic.
REQ-003 rst_n  in  1  asynchronous reset, active-low.
REQ-004 avl_address  in  5  Avalon byte address; bits [4:2] select the UART register.
REQ-005 avl_read / avl_write  in  1 each  Avalon commands.
REQ-006 avl_writedata  in  32  write data; only [7:0] is used.
REQ-007 avl_byteenable  in  4  accepted and ignored.
REQ-008 avl_waitrequest  out  1  Avalon stall.
REQ-009 avl_readdata  out  32  read data, {24'd0, byte}.
REQ-010 avl_readdatavalid  out  1  read data strobe.
REQ-011 avl_response  out  2  2'b00 OKAY, 2'b10 SLAVEERROR.
REQ-012 wb_adr_o  out  3  register index.
REQ-013 wb_dat_o  out  8  write data.
REQ-014 wb_dat_i  in  8  read data.
REQ-015 wb_we_o, wb_stb_o, wb_cyc_o  out  1 each  Wishbone controls.
REQ-016 wb_sel_o  out  4  constant 4'b0001.
REQ-017 wb_ack_i  in  1  Wishbone acknowledge.
REQ-018 timeout_o  out  1  one-cycle abort pulse.

Function
REQ-019 The FSM SHALL have two states, IDLE and WB_REQ.
REQ-020 In IDLE with init_done=1 and (avl_read|avl_write), the bridge SHALL accept the command: avl_waitrequest=0 in the same cycle, and it SHALL register address[4:2], writedata[7:0], we=avl_write, then enter WB_REQ.
REQ-021 In all other cycles, avl_waitrequest SHALL be 1.
REQ-022 If avl_read and avl_write are both high, the command SHALL be treated as a write and no readdatavalid SHALL follow.
REQ-023 In WB_REQ, wb_cyc_o=wb_stb_o=1 and wb_adr_o/wb_dat_o/wb_we_o SHALL be held stable from the registered values; these outputs SHALL be 0 in IDLE.
REQ-024 On wb_ack_i in WB_REQ, the FSM SHALL return to IDLE next cycle.
REQ-025 For a read ack, avl_readdatavalid=1 and avl_readdata={24'd0, wb_dat_i captured at ack} SHALL be driven for exactly one cycle, the cycle after the ack.
REQ-026 Minimum read latency SHALL be 2 cycles (accept T, stb T+1, ack T+1, readdatavalid T+2); a new command SHALL be acceptable at T+2.
REQ-027 wb_ack_i in IDLE SHALL be ignored.
REQ-028 avl_response SHALL be 2'b00 except as defined in REQ-033.
REQ-029 avl_readdata SHALL hold its last value when readdatavalid=0.

Reset
REQ-030 While rst_n=0: state=IDLE, init_done=0, and all registered outputs (readdata, readdatavalid, response, wb_*_o except wb_sel_o, timeout_o, timeout counter) SHALL be 0; avl_waitrequest SHALL be 1.
REQ-031 init_done SHALL become 1 on the first clk edge after rst_n rises; commands SHALL be accepted only after that edge.
REQ-032 Reset mid-transaction SHALL abort immediately: cyc/stb drop asynchronously, and no readdatavalid is produced for the aborted command.

Configuration
REQ-033 With AVL_WB_BRIDGE_TIMEOUT_EN defined:
- A 16-bit counter SHALL clear on entry to WB_REQ and increment each WB_REQ cycle without ack.
- When it reaches TIMEOUT_CYCLES, the bridge SHALL drop cyc/stb, return to IDLE, and pulse timeout_o for one cycle.
- If that abort is a read, it SHALL give readdatavalid=1, readdata=0, response=2'b10 one cycle later.
- An ack in the same cycle as the limit SHALL take priority (normal completion).
REQ-034 Without the macro, WB_REQ SHALL wait indefinitely for ack, timeout_o SHALL be tied 0, and avl_response SHALL be constant 2'b00.

Verification
REQ-035 Read address 5'h14, ack 1 cycle after stb with wb_dat_i=8'h60 -> wb_adr_o=3'd5, readdatavalid 2 cycles after accept, readdata=32'h00000060, response 2'b00.
REQ-036 Write address 5'h00, data 32'hAABBCC41, ack delayed 4 cycles -> wb_dat_o=8'h41, wb_we_o=1, cyc/stb held 4 cycles, waitrequest=1 for a second command until IDLE, no readdatavalid.
REQ-037 avl_read held high continuously with ack each stb -> one accept every 2 cycles, one readdatavalid per accept, no duplicates.
REQ-038 TIMEOUT_EN, TIMEOUT_CYCLES=8, read with ack never asserted -> stb high 8 cycles, timeout_o pulse, readdata=0, response=2'b10; a following read acked normally returns 2'b00.
REQ-039 rst_n pulled low during WB_REQ of a read -> cyc/stb=0 immediately, no readdatavalid; after release, first command accepted no earlier than the second clk edge.
